// File: rtl/cs_accum_pkg.sv
// Shared types and elaboration helpers for the carry-save accumulator.
package cs_accum_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  function automatic int n_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit chunk_legal(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/cs_accum_cmprs_3to2.sv
// 3:2 compressor (full-adder) cell used to build the carry-save row.
module cmprs_3to2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/cs_accum.sv
// Carry-save accumulator with chunked carry-propagate resolve.
// Define CS_ACCUM_FAST_RESOLVE_EN for a single-cycle full-width resolve.
//
// state   | meaning
// ACC     | accept operands into the redundant s/c pair
// RESOLVE | carry-propagate s+c into r
// OUT     | hold r on out_data until out_ready
module cs_accum
  import cs_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (!chunk_legal(WIDTH, CHUNK)) begin : g_param_err
    $error("cs_accum: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_maj;

  for (genvar i = 0; i < WIDTH; i++) begin : g_csa
    cmprs_3to2 u_cmprs (
      .a    (s[i]),
      .b    (c[i]),
      .c    (in_data[i]),
      .sum  (csa_sum[i]),
      .cout (csa_maj[i])
    );
  end

`ifndef CS_ACCUM_FAST_RESOLVE_EN
  localparam int N  = n_chunks(WIDTH, CHUNK);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0]  idx;
  logic           cin;
  logic [CHUNK:0] chunk_sum;

  assign chunk_sum = {1'b0, s[idx*CHUNK +: CHUNK]} + {1'b0, c[idx*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cin};
`endif

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign out_data  = r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      s     <= '0;
      c     <= '0;
      r     <= '0;
`ifndef CS_ACCUM_FAST_RESOLVE_EN
      idx   <= '0;
      cin   <= 1'b0;
`endif
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            s <= csa_sum;
            // bit WIDTH-1 of the majority term falls off: modulo 2^WIDTH
            c <= csa_maj << 1;
            if (in_last) begin
              state <= RESOLVE;
`ifndef CS_ACCUM_FAST_RESOLVE_EN
              idx   <= '0;
              cin   <= 1'b0;
`endif
            end
          end
        end
        RESOLVE: begin
`ifdef CS_ACCUM_FAST_RESOLVE_EN
          r     <= s + c;
          state <= OUT;
`else
          r[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cin <= chunk_sum[CHUNK];
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= OUT;
`endif
        end
        OUT: begin
          if (out_ready) begin
            s     <= '0;
            c     <= '0;
            r     <= '0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_accum.sv
// Self-checking bench for cs_accum: directed scenarios plus random sums
// compared against a plain modulo-2^32 running total.
module tb_cs_accum;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
`ifdef CS_ACCUM_FAST_RESOLVE_EN
  localparam int LAT      = 2;
  localparam int RST_WAIT = 0;
`else
  localparam int LAT      = N + 1;
  localparam int RST_WAIT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  cs_accum #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    check("in_ready_acc", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  // Call right after the accept edge of the last operand.
  task automatic collect(input string tag, input logic [31:0] exp, input int hold);
    int edges;
    logic [31:0] held;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 50) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, LAT);
    check({tag, "_data"}, out_data, exp);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_data  = $urandom;
      tick();
      check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_data"}, out_data, held);
      check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] total;
    logic [31:0] d;
    int          n;

    repeat (2) tick();
    rst = 1'b0;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);

    send(32'h1234_5678, 1'b1);
    collect("single", 32'h1234_5678, 0);

    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0001, 1'b1);
    collect("wrap", 32'h0000_0001, 1);

    send(32'h00FF_FFFF, 1'b0);
    send(32'h0000_0001, 1'b1);
    collect("chunk_carry", 32'h0100_0000, 0);

    send(32'h8000_0000, 1'b0);
    send(32'h8000_0000, 1'b1);
    collect("top_carry_drop", 32'h0000_0000, 0);

    send(32'hDEAD_BEEF, 1'b1);
    collect("backpressure", 32'hDEAD_BEEF, 6);

    send(32'h0000_1111, 1'b0);
    send(32'h2222_0000, 1'b1);
    repeat (RST_WAIT) tick();
    check("abort_no_output", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_out_data", out_data, 32'd0);
    send(32'd5, 1'b0);
    send(32'd7, 1'b1);
    collect("after_abort", 32'h0000_000C, 0);

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 7);
      total = '0;
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0:       d = 32'hFFFF_FFFF;
          1:       d = 32'h00FF_FFFF << (8 * $urandom_range(0, 1));
          default: d = $urandom;
        endcase
        total = total + d;
        if ($urandom_range(0, 3) == 0) tick();
        send(d, j == n - 1);
      end
      collect("random", total, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
